// File: rtl/light_sequencer.sv
// light_sequencer: table-driven light-show player with pre-roll, loops, pause and abort.
// Optional build macro LIGHT_SEQ_MIRROR_EN mirrors the low half of each pattern onto the high half.
module light_sequencer #(
    parameter int NUM_LIGHTS     = 8,
    parameter int NUM_STEPS      = 64,
    parameter int DUR_W          = 16,
    parameter int LOOP_W         = 4,
    parameter int CLKS_PER_MS    = 5000,
    parameter int START_DELAY_MS = 20000,
    localparam int ADDR_W        = $clog2(NUM_STEPS),
    localparam int ENTRY_W       = NUM_LIGHTS + DUR_W + ADDR_W + LOOP_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic                  abort,
    input  logic                  pause,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [ENTRY_W-1:0]    wr_data,
    output logic                  busy,
    output logic                  finished,
    output logic [ADDR_W-1:0]     step_idx,
    output logic [NUM_LIGHTS-1:0] lights
);

    localparam int DLY_W = $clog2(START_DELAY_MS + 1);
    localparam int MS_W  = (DUR_W > DLY_W) ? DUR_W : DLY_W;
    localparam int PS_W  = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

    localparam int DUR_LO = NUM_LIGHTS;
    localparam int TGT_LO = DUR_LO + DUR_W;
    localparam int CNT_LO = TGT_LO + ADDR_W;
    localparam int END_B  = ENTRY_W - 1;

    localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(CLKS_PER_MS - 1);
    localparam logic [MS_W-1:0]   DLY_MS   = MS_W'(START_DELAY_MS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PLAY  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PS_W-1:0]       psc_q, psc_d;
    logic [MS_W-1:0]       ms_q, ms_d;
    logic [LOOP_W-1:0]     loop_q, loop_d;
    logic [ADDR_W-1:0]     idx_q, idx_d;
    logic [NUM_LIGHTS-1:0] lights_q, lights_d;
    logic                  fin_q, fin_d;
    logic                  load, clr;

    logic [ENTRY_W-1:0]    table_q [NUM_STEPS];
    logic                  wr_ok;

    logic [ENTRY_W-1:0]    cur;
    logic [DUR_W-1:0]      cur_dur;
    logic [ADDR_W-1:0]     cur_tgt;
    logic [LOOP_W-1:0]     cur_cnt;
    logic                  cur_end;
    logic [MS_W-1:0]       dur_eff;
    logic                  tick;
    logic [PS_W-1:0]       psc_adv;
    logic [MS_W-1:0]       ms_inc;
    logic [ENTRY_W-1:0]    nxt_entry;

    // Fold a stored pattern onto the output channels.
    function automatic logic [NUM_LIGHTS-1:0] map_pat(
        input logic [NUM_LIGHTS-1:0] p
    );
        logic [NUM_LIGHTS-1:0] m;
`ifdef LIGHT_SEQ_MIRROR_EN
        m = '0;
        for (int i = 0; i < NUM_LIGHTS / 2; i++) begin
            m[i]                  = p[i];
            m[i + NUM_LIGHTS / 2] = p[i];
        end
        if ((NUM_LIGHTS % 2) == 1) begin
            m[NUM_LIGHTS-1] = p[NUM_LIGHTS-1];
        end
`else
        m = p;
`endif
        return m;
    endfunction

    assign wr_ok = wr_en && (state_q == IDLE);

    // Step table: writable only while idle, survives reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            table_q[wr_addr] <= wr_data;
        end
    end

    assign cur     = table_q[idx_q];
    assign cur_dur = cur[TGT_LO-1:DUR_LO];
    assign cur_tgt = cur[CNT_LO-1:TGT_LO];
    assign cur_cnt = cur[END_B-1:CNT_LO];
    assign cur_end = cur[END_B];
    assign dur_eff = (cur_dur == '0) ? MS_W'(1) : MS_W'(cur_dur);

    assign tick    = (psc_q == PS_LAST);
    assign psc_adv = tick ? '0 : psc_q + 1'b1;
    assign ms_inc  = ms_q + 1'b1;

    // Sequencing: pre-roll, step timing, loop and end handling.
    always_comb begin
        state_d = state_q;
        psc_d   = psc_q;
        ms_d    = ms_q;
        loop_d  = loop_q;
        idx_d   = idx_q;
        fin_d   = 1'b0;
        load    = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            IDLE: begin
                clr = 1'b1;
                if (go) begin
                    psc_d  = '0;
                    ms_d   = '0;
                    loop_d = '0;
                    idx_d  = '0;
                    if (START_DELAY_MS == 0) begin
                        state_d = PLAY;
                        load    = 1'b1;
                        clr     = 1'b0;
                    end else begin
                        state_d = DELAY;
                    end
                end
            end
            DELAY: begin
                if (abort) begin
                    state_d = IDLE;
                    clr     = 1'b1;
                end else if (!pause) begin
                    psc_d = psc_adv;
                    if (tick) begin
                        if (ms_inc == DLY_MS) begin
                            ms_d    = '0;
                            idx_d   = '0;
                            state_d = PLAY;
                            load    = 1'b1;
                        end else begin
                            ms_d = ms_inc;
                        end
                    end
                end
            end
            PLAY: begin
                if (abort) begin
                    state_d = IDLE;
                    clr     = 1'b1;
                end else if (!pause) begin
                    psc_d = psc_adv;
                    if (tick) begin
                        if (ms_inc == dur_eff) begin
                            ms_d = '0;
                            if (cur_cnt != '0 && loop_q < cur_cnt) begin
                                loop_d = loop_q + 1'b1;
                                idx_d  = cur_tgt;
                                load   = 1'b1;
                            end else begin
                                if (cur_cnt != '0) begin
                                    loop_d = '0;
                                end
                                if (cur_end || idx_q == LAST_IDX) begin
                                    state_d = IDLE;
                                    fin_d   = 1'b1;
                                    clr     = 1'b1;
                                end else begin
                                    idx_d = idx_q + 1'b1;
                                    load  = 1'b1;
                                end
                            end
                        end else begin
                            ms_d = ms_inc;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                clr     = 1'b1;
            end
        endcase
    end

    // Entry about to be shown; forwards a same-cycle write on the go cycle.
    always_comb begin
        nxt_entry = table_q[idx_d];
        if (wr_ok && wr_addr == idx_d) begin
            nxt_entry = wr_data;
        end
    end

    // Next light pattern: blank, new step, or hold.
    always_comb begin
        lights_d = lights_q;
        if (clr) begin
            lights_d = '0;
        end else if (load) begin
            lights_d = map_pat(nxt_entry[NUM_LIGHTS-1:0]);
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            psc_q    <= '0;
            ms_q     <= '0;
            loop_q   <= '0;
            idx_q    <= '0;
            lights_q <= '0;
            fin_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            psc_q    <= psc_d;
            ms_q     <= ms_d;
            loop_q   <= loop_d;
            idx_q    <= idx_d;
            lights_q <= lights_d;
            fin_q    <= fin_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign finished = fin_q;
    assign step_idx = idx_q;
    assign lights   = lights_q;

endmodule
